// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word over valid/ready and sends it one bit per clock.
// Define PISO_PARITY_EN to append an even-parity bit (^din) after the last data bit.
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_bar,
    output logic             frame,
    output logic             busy,
    output logic             done
);

`ifdef PISO_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int CW = $clog2(N + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg;
    logic [N-1:0]     shift_reg;
    logic [CW-1:0]    cnt_reg;
    logic             sout_reg;
    logic             sout_bar_reg;
    logic             ready_reg;
    logic             frame_reg;
    logic             busy_reg;
    logic             done_reg;

    // ordered[k] is the k-th bit to appear on the wire, so the shifter
    // always drains from bit 0 regardless of the configured bit order.
    logic [WIDTH-1:0] ordered;
    logic [N-1:0]     seq_word;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
        if (MSB_FIRST) begin : g_msb
            assign ordered[gi] = din[WIDTH-1-gi];
        end else begin : g_lsb
            assign ordered[gi] = din[gi];
        end
    end

`ifdef PISO_PARITY_EN
    assign seq_word = {^din, ordered};
`else
    assign seq_word = ordered;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            cnt_reg      <= '0;
            sout_reg     <= 1'b0;
            sout_bar_reg <= 1'b1;
            ready_reg    <= 1'b1;
            frame_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (load_valid) begin
                        // First bit goes straight to sout; the rest wait in the shifter.
                        state_reg    <= SHIFT;
                        shift_reg    <= seq_word >> 1;
                        cnt_reg      <= '0;
                        sout_reg     <= seq_word[0];
                        sout_bar_reg <= ~seq_word[0];
                        ready_reg    <= 1'b0;
                        frame_reg    <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt_reg == CW'(N - 1)) begin
                        state_reg    <= IDLE;
                        cnt_reg      <= '0;
                        sout_reg     <= 1'b0;
                        sout_bar_reg <= 1'b1;
                        ready_reg    <= 1'b1;
                        frame_reg    <= 1'b0;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                    end else begin
                        cnt_reg      <= cnt_reg + CW'(1);
                        shift_reg    <= shift_reg >> 1;
                        sout_reg     <= shift_reg[0];
                        sout_bar_reg <= ~shift_reg[0];
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign load_ready = ready_reg;
    assign sout       = sout_reg;
    assign sout_bar   = sout_bar_reg;
    assign frame      = frame_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule
